// File: rtl/ncc_sequencer_if.sv
// Descriptor/window handshakes and PE-grid control strobes shared between
// ncc_sequencer (master) and the NCC grid plus its feeders (slave).
interface ncc_sequencer_if #(
   parameter int unsigned NUM_ROWS    = 16,
   parameter int unsigned COL_GROUPS  = 4,
   parameter int unsigned WINDOW_COLS = 640
);
   logic                           desc_valid;
   logic                           desc_ready;
   logic                           desc_load;
   logic [$clog2(NUM_ROWS)-1:0]    desc_row;
   logic [$clog2(COL_GROUPS)-1:0]  desc_col_group;
   logic                           win_valid;
   logic                           win_ready;
   logic                           win_flush;
   logic                           loadWinReg;
   logic                           loadAccSumReg;
   logic                           score_valid;
   logic [$clog2(WINDOW_COLS)-1:0] score_col;

   modport master (
      input  desc_valid, win_valid,
      output desc_ready, desc_load, desc_row, desc_col_group,
             win_ready, win_flush, loadWinReg, loadAccSumReg,
             score_valid, score_col
   );

   modport slave (
      output desc_valid, win_valid,
      input  desc_ready, desc_load, desc_row, desc_col_group,
             win_ready, win_flush, loadWinReg, loadAccSumReg,
             score_valid, score_col
   );
endinterface

// File: rtl/ncc_sequencer.sv
// Control sequencer for the log-domain NCC PE grid: descriptor load, window
// streaming, accumulator drain and score flagging for the peak finder.
module ncc_sequencer #(
   parameter int unsigned NUM_ROWS    = 16,
   parameter int unsigned COL_GROUPS  = 4,
   parameter int unsigned WINDOW_COLS = 640,
   parameter int unsigned PIPE_LAT    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   ncc_sequencer_if.master bus,
   output logic           busy,
   output logic           done
);
   localparam int unsigned RW = $clog2(NUM_ROWS);
   localparam int unsigned CW = $clog2(COL_GROUPS);
   localparam int unsigned AW = $clog2(WINDOW_COLS + PIPE_LAT);
   localparam int unsigned SW = $clog2(WINDOW_COLS);

   localparam logic [RW-1:0] ROW_LAST        = RW'(NUM_ROWS - 1);
   localparam logic [CW-1:0] CG_LAST         = CW'(COL_GROUPS - 1);
   localparam logic [AW-1:0] ADV_WIN_LAST    = AW'(WINDOW_COLS - 1);
   localparam logic [AW-1:0] ADV_DRAIN_LAST  = AW'(WINDOW_COLS + PIPE_LAT - 2);
   localparam logic [AW-1:0] ADV_FIRST_SCORE = AW'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DESC_LOAD = 3'd1,
      S_WIN       = 3'd2,
      S_DRAIN     = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] cg_q, cg_d;
   logic [AW-1:0] adv_q, adv_d;
   logic          score_valid_q, score_valid_d;
   logic [SW-1:0] score_col_q, score_col_d;
   logic          done_q, done_d;
   logic          desc_ready_s, desc_load_s, win_ready_s, win_flush_s, advance_s;

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      cg_d          = cg_q;
      adv_d         = adv_q;
      score_valid_d = 1'b0;
      score_col_d   = score_col_q;
      desc_ready_s  = 1'b0;
      desc_load_s   = 1'b0;
      win_ready_s   = 1'b0;
      win_flush_s   = 1'b0;
      advance_s     = 1'b0;
      // abort is checked before any handshake so it always wins
      case (state_q)
         S_IDLE: begin
            if (start && !abort) state_d = S_DESC_LOAD;
            else                 state_d = S_IDLE;
         end
         S_DESC_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               desc_ready_s = 1'b1;
               desc_load_s  = bus.desc_valid;
               if (bus.desc_valid) begin
                  if (cg_q == CG_LAST) begin
                     cg_d = '0;
                     if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = S_WIN;
                     end else begin
                        row_d = row_q + RW'(1);
                     end
                  end else begin
                     cg_d = cg_q + CW'(1);
                  end
               end
            end
         end
         S_WIN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               win_ready_s = 1'b1;
               advance_s   = bus.win_valid;
               if (bus.win_valid && adv_q == ADV_WIN_LAST) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               win_flush_s = 1'b1;
               advance_s   = 1'b1;
               if (adv_q == ADV_DRAIN_LAST) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // a score leaves the end of the accumulator chain PIPE_LAT-1 advances late
      if (advance_s) begin
         adv_d = adv_q + AW'(1);
         if (adv_q >= ADV_FIRST_SCORE) begin
            score_valid_d = 1'b1;
            score_col_d   = SW'(adv_q - ADV_FIRST_SCORE);
         end
      end

      if (state_d == S_IDLE) begin
         row_d = '0;
         cg_d  = '0;
         adv_d = '0;
      end

      done_d = (state_d == S_DONE);
   end

   // state, counters and registered score/done outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         row_q         <= '0;
         cg_q          <= '0;
         adv_q         <= '0;
         score_valid_q <= 1'b0;
         score_col_q   <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         cg_q          <= cg_d;
         adv_q         <= adv_d;
         score_valid_q <= score_valid_d;
         score_col_q   <= score_col_d;
         done_q        <= done_d;
      end
   end

   assign bus.desc_ready     = desc_ready_s;
   assign bus.desc_load      = desc_load_s;
   assign bus.desc_row       = row_q;
   assign bus.desc_col_group = cg_q;
   assign bus.win_ready      = win_ready_s;
   assign bus.win_flush      = win_flush_s;
   assign bus.loadWinReg     = advance_s;
   assign bus.loadAccSumReg  = advance_s;
   assign bus.score_valid    = score_valid_q;
   assign bus.score_col      = score_col_q;
   assign busy               = (state_q != S_IDLE);
   assign done               = done_q;
endmodule

// File: tb/tb_ncc_sequencer.sv
// Scoreboard bench for ncc_sequencer: a default-size instance (A) and a
// WINDOW_COLS=20 instance (B) for the window-stall scenario.
module tb_ncc_sequencer;
   localparam int W_B = 20;

   logic clk = 1'b0;
   logic rst;
   logic start_a, abort_a, busy_a, done_a;
   logic start_b, abort_b, busy_b, done_b;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   int exp_desc_a[$];
   int exp_sc_a[$];
   int exp_done_a[$];
   int exp_sc_b[$];
   int exp_done_b[$];

   int done_cnt_a = 0, last_done_cyc_a = 0, first_sc_cyc_a = 0, adv_a = 0, flush_a = 0;
   int done_cnt_b = 0, adv_b = 0;

   ncc_sequencer_if                      bus_a ();
   ncc_sequencer_if #(.WINDOW_COLS(W_B)) bus_b ();

   ncc_sequencer dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .bus(bus_a), .busy(busy_a), .done(done_a)
   );

   ncc_sequencer #(.WINDOW_COLS(W_B)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .bus(bus_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] strobes_a();
      return {bus_a.desc_ready, bus_a.desc_load, bus_a.win_ready, bus_a.win_flush,
              bus_a.loadWinReg, bus_a.loadAccSumReg, bus_a.score_valid, busy_a, done_a};
   endfunction

   task automatic push_a();
      for (int i = 0; i < 64; i++)  exp_desc_a.push_back(i);
      for (int i = 0; i < 640; i++) exp_sc_a.push_back(i);
      exp_done_a.push_back(1);
   endtask

   task automatic flush_a_q();
      exp_desc_a.delete();
      exp_sc_a.delete();
      exp_done_a.delete();
   endtask

   task automatic wait_done_a(input int base);
      for (int i = 0; i < 2000 && done_cnt_a == base; i++) tick();
      chk("A done pulse count", done_cnt_a - base, 1);
      chk("A scoreboard drained", exp_desc_a.size() + exp_sc_a.size() + exp_done_a.size(), 0);
   endtask

   // monitor A: pop expectations whenever the DUT presents a load, score or done
   always @(negedge clk) begin
      int e;
      if (bus_a.desc_load) begin
         e = (exp_desc_a.size() != 0) ? exp_desc_a.pop_front() : 9999;
         chk("A desc_row", bus_a.desc_row, e / 4);
         chk("A desc_col_group", bus_a.desc_col_group, e % 4);
      end
      if (bus_a.loadWinReg || bus_a.loadAccSumReg) begin
         chk("A loadWinReg", bus_a.loadWinReg, 1);
         chk("A loadAccSumReg", bus_a.loadAccSumReg, 1);
         adv_a = adv_a + 1;
         if (bus_a.win_flush) flush_a = flush_a + 1;
      end
      if (bus_a.score_valid) begin
         e = (exp_sc_a.size() != 0) ? exp_sc_a.pop_front() : 9999;
         chk("A score_col", bus_a.score_col, e);
         if (e == 0) first_sc_cyc_a = cyc;
      end
      if (done_a) begin
         chk("A done expected", exp_done_a.size(), 1);
         if (exp_done_a.size() != 0) e = exp_done_a.pop_front();
         chk("A last score with done", bus_a.score_valid, 1);
         done_cnt_a      = done_cnt_a + 1;
         last_done_cyc_a = cyc;
      end
   end

   // monitor B: scores and done of the short-window instance
   always @(negedge clk) begin
      int e;
      if (bus_b.loadWinReg) adv_b = adv_b + 1;
      if (bus_b.score_valid) begin
         e = (exp_sc_b.size() != 0) ? exp_sc_b.pop_front() : 9999;
         chk("B score_col", bus_b.score_col, e);
      end
      if (done_b) begin
         chk("B done expected", exp_done_b.size(), 1);
         if (exp_done_b.size() != 0) e = exp_done_b.pop_front();
         done_cnt_b = done_cnt_b + 1;
      end
   end

   initial begin
      int s, base, n, adv0, fl0;
      bit dv;
      rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      bus_a.desc_valid = 1'b0; bus_a.win_valid = 1'b0;
      bus_b.desc_valid = 1'b0; bus_b.win_valid = 1'b0;
      repeat (3) tick();
      chk("reset A strobes", strobes_a(), 0);
      chk("reset A indices", {bus_a.desc_row, bus_a.desc_col_group, bus_a.score_col}, 0);
      chk("reset B busy/done/score", {busy_b, done_b, bus_b.score_valid, bus_b.score_col}, 0);
      rst = 1'b0;
      tick();

      // continuous valids, default geometry, with a start while busy
      push_a();
      base = done_cnt_a; adv0 = adv_a; fl0 = flush_a;
      bus_a.desc_valid = 1'b1; bus_a.win_valid = 1'b1;
      start_a = 1'b1; s = cyc; #1;
      chk("A desc_ready in start cycle", bus_a.desc_ready, 0);
      tick(); start_a = 1'b0;
      chk("A start to desc_ready", bus_a.desc_ready, 1);
      chk("A busy", busy_a, 1);
      repeat (8) tick();
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_done_a(base);
      chk("A first score cycle", first_sc_cyc_a - s, 81);
      chk("A done cycle", last_done_cyc_a - s, 720);
      chk("A total advances", adv_a - adv0, 655);
      chk("A drain advances", flush_a - fl0, 15);
      chk("A idle after done", busy_a, 0);

      // descriptor stalls: desc_valid toggling 1,0,1,0
      push_a();
      base = done_cnt_a;
      bus_a.desc_valid = 1'b0;
      start_a = 1'b1; tick(); start_a = 1'b0;
      n = 0; dv = 1'b1;
      for (int g = 0; g < 300 && n < 64; g++) begin
         bus_a.desc_valid = dv; #1;
         chk("A stall desc_load", bus_a.desc_load, dv);
         chk("A stall desc_row", bus_a.desc_row, n / 4);
         chk("A stall desc_col_group", bus_a.desc_col_group, n % 4);
         if (dv) n++;
         dv = !dv;
         tick();
      end
      bus_a.desc_valid = 1'b0; #1;
      chk("A win_ready after 64th load", bus_a.win_ready, 1);
      chk("A desc_ready after 64th load", bus_a.desc_ready, 0);
      wait_done_a(base);

      // abort after 30 descriptor words, then restart from row 0
      push_a();
      bus_a.desc_valid = 1'b1;
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (30) tick();
      abort_a = 1'b1; #1;
      chk("A abort blocks desc_load", bus_a.desc_load, 0);
      chk("A abort drops desc_ready", bus_a.desc_ready, 0);
      tick(); abort_a = 1'b0;
      chk("A busy after desc abort", busy_a, 0);
      chk("A descriptor words left", exp_desc_a.size(), 34);
      flush_a_q();
      push_a();
      base = done_cnt_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      chk("A restart desc_row", bus_a.desc_row, 0);
      chk("A restart desc_col_group", bus_a.desc_col_group, 0);
      wait_done_a(base);

      // abort in DRAIN with a score pending
      push_a();
      base = done_cnt_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int i = 0; i < 1000 && !bus_a.win_flush; i++) tick();
      chk("A reached drain", bus_a.win_flush, 1);
      repeat (3) tick();
      abort_a = 1'b1; #1;
      chk("A abort drops win_flush", bus_a.win_flush, 0);
      chk("A abort drops loadWinReg", bus_a.loadWinReg, 0);
      chk("A score pending at abort", bus_a.score_valid, 1);
      tick(); abort_a = 1'b0;
      chk("A busy after drain abort", busy_a, 0);
      chk("A score suppressed", bus_a.score_valid, 0);
      chk("A scores left", exp_sc_a.size(), 12);
      flush_a_q();
      repeat (30) tick();
      chk("A no done after abort", done_cnt_a - base, 0);

      // rst during WIN_STREAM with win_valid high
      push_a();
      start_a = 1'b1; tick(); start_a = 1'b0;
      for (int i = 0; i < 200 && !bus_a.win_ready; i++) tick();
      repeat (20) tick();
      rst = 1'b1; #1;
      chk("A rst waits for edge", bus_a.loadWinReg, 1);
      tick();
      chk("A rst strobes", strobes_a(), 0);
      chk("A rst indices", {bus_a.desc_row, bus_a.desc_col_group, bus_a.score_col}, 0);
      rst = 1'b0;
      flush_a_q();

      // start and abort together in IDLE
      start_a = 1'b1; abort_a = 1'b1; tick();
      start_a = 1'b0; abort_a = 1'b0;
      chk("A start+abort stays idle", busy_a, 0);
      chk("A start+abort no desc_ready", bus_a.desc_ready, 0);

      // WINDOW_COLS=20 with a 5-cycle window stall after the 10th pixel
      for (int i = 0; i < W_B; i++) exp_sc_b.push_back(i);
      exp_done_b.push_back(1);
      base = done_cnt_b; adv0 = adv_b;
      bus_b.desc_valid = 1'b1;
      start_b = 1'b1; tick(); start_b = 1'b0;
      for (int i = 0; i < 200 && !bus_b.win_ready; i++) tick();
      chk("B reached window stream", bus_b.win_ready, 1);
      for (int i = 0; i < 10; i++) begin
         bus_b.win_valid = 1'b1; #1;
         chk("B advance", bus_b.loadWinReg, 1);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         bus_b.win_valid = 1'b0; #1;
         chk("B stall frozen", {bus_b.loadWinReg, bus_b.loadAccSumReg}, 0);
         tick();
      end
      bus_b.win_valid = 1'b1;
      for (int i = 0; i < 200 && done_cnt_b == base; i++) tick();
      chk("B done pulse count", done_cnt_b - base, 1);
      chk("B total advances", adv_b - adv0, 35);
      chk("B scoreboard drained", exp_sc_b.size() + exp_done_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
